pwm_burst_sequencer: RTL and testbench

- Programmable two-phase waveform generator. Drives `pwm_out` high for `high_len+1` cycles, then low for `low_len+1` cycles, and repeats the period `reps` times (or forever).
- Sits directly upstream of the team's existing `counter` module. It drives the counter's `enable`, `srst` and `count_to`, and consumes its `done` to sequence phases.
- Feeds timing/strobe consumers downstream (PWM pads, sample triggers).

---
 rtl/pwm_seq_pkg.sv | 18 +
 rtl/counter.sv | 42 ++++
 rtl/pwm_burst_sequencer.sv | 154 +++++++++++++++
 tb/tb_pwm_burst_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg
//   Shared types for the PWM burst sequencer.
//   pwm_state_e : sequencer phase (IDLE, HIGH, LOW), encoded from the
//                 localparams below so other blocks can decode them too.

package pwm_seq_pkg;

    localparam logic [1:0] PWM_ST_IDLE = 2'b00;
    localparam logic [1:0] PWM_ST_HIGH = 2'b01;
    localparam logic [1:0] PWM_ST_LOW  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = PWM_ST_IDLE,
        HIGH = PWM_ST_HIGH,
        LOW  = PWM_ST_LOW
    } pwm_state_e;

endpackage

// File: rtl/counter.sv
// counter
//   Free-running up counter with programmable terminal value.
//   Counts up every enabled cycle. When the count reaches count_to, done
//   is raised for that cycle and the count wraps to 0 on the next edge.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset (count <= INIT_VAL)
//   srst      synchronous clear (count <= INIT_VAL), beats enable/wrap
//   enable    advance the count this cycle
//   count_to  terminal value
//   done      enable & (count == count_to), combinational

module counter #(
    parameter int              W        = 8,
    parameter logic [W-1:0]    INIT_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         srst,
    input  logic         enable,
    input  logic [W-1:0] count_to,
    output logic         done
);

    logic [W-1:0] count;

    assign done = enable && (count == count_to);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= INIT_VAL;
        end else if (srst) begin
            count <= INIT_VAL;
        end else if (done) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_burst_sequencer.sv
// pwm_burst_sequencer
//   Two-phase waveform generator: pwm_out high for high_len+1 cycles,
//   then low for low_len+1 cycles, repeated reps times (reps=0: until
//   stop). Phase timing comes from one counter instance whose done
//   output marks the last cycle of each phase.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           burst request, taken only when start_ready=1
//   start_ready     idle indication (!busy)
//   stop            synchronous abort, highest priority
//   high_len        HIGH phase length minus one (latched on start)
//   low_len         LOW phase length minus one (latched on start)
//   reps            number of periods, 0 = endless (latched on start)
//   busy            state != IDLE
//   pwm_out         state == HIGH
//   period_tick     pulse on the final cycle of every LOW phase
//   burst_done      pulse on the final cycle of the last period
//   reps_left       periods remaining including the current one

module pwm_burst_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int W = 8,
    parameter int R = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         start_ready,
    input  logic         stop,
    input  logic [W-1:0] high_len,
    input  logic [W-1:0] low_len,
    input  logic [R-1:0] reps,
    output logic         busy,
    output logic         pwm_out,
    output logic         period_tick,
    output logic         burst_done,
    output logic [R-1:0] reps_left
);

    pwm_state_e   state;
    pwm_state_e   state_d;
    logic [W-1:0] high_q;
    logic [W-1:0] low_q;
    logic [R-1:0] reps_q;
    logic [R-1:0] reps_left_q;
    logic [W-1:0] cnt_to;
    logic         cnt_srst;
    logic         cnt_done;
    logic         accept;
    logic         period_end;

    // Registered-state decodes only, so busy/pwm_out never glitch.
    assign busy        = (state != IDLE);
    assign pwm_out     = (state == HIGH);
    assign start_ready = !busy;
    assign reps_left   = reps_left_q;

    assign accept     = start && start_ready && !stop;
    assign period_end = (state == LOW) && cnt_done && !stop;

    // Holding the counter cleared in IDLE guarantees a zero count on the
    // first HIGH cycle; between phases the counter's own wrap suffices.
    assign cnt_srst = (state == IDLE) || stop;

    always_comb begin
        cnt_to = '0;
        case (state)
            HIGH:    cnt_to = high_q;
            LOW:     cnt_to = low_q;
            default: cnt_to = '0;
        endcase
    end

    counter #(
        .W        (W),
        .INIT_VAL ('0)
    ) u_counter (
        .clk      (clk),
        .rst      (!rst_n),
        .srst     (cnt_srst),
        .enable   (1'b1),
        .count_to (cnt_to),
        .done     (cnt_done)
    );

    always_comb begin
        state_d     = state;
        period_tick = 1'b0;
        burst_done  = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_d = HIGH;
                end
                HIGH: begin
                    if (cnt_done) state_d = LOW;
                end
                LOW: begin
                    if (cnt_done) begin
                        period_tick = 1'b1;
                        if (reps_q == '0) begin
                            state_d = HIGH;
                        end else if (reps_left_q == R'(1)) begin
                            burst_done = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = HIGH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q <= '0;
            low_q  <= '0;
            reps_q <= '0;
        end else if (accept) begin
            high_q <= high_len;
            low_q  <= low_len;
            reps_q <= reps;
        end
    end

    // Endless mode (reps_q==0) leaves reps_left at 0; the !=0 guard keeps
    // the decrement from ever wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reps_left_q <= '0;
        end else if (stop) begin
            reps_left_q <= '0;
        end else if (accept) begin
            reps_left_q <= reps;
        end else if (period_end && (reps_q != '0) && (reps_left_q != '0)) begin
            reps_left_q <= reps_left_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_burst_sequencer.sv
// tb_pwm_burst_sequencer
//   Self-checking bench for pwm_burst_sequencer. The reference model
//   describes a burst by the cycle number k since the accepted start:
//   period index = (k-1)/P, position = (k-1)%P with P = high+low+2.

module tb_pwm_burst_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [7:0] reps;
    logic       start_ready;
    logic       busy;
    logic       pwm_out;
    logic       period_tick;
    logic       burst_done;
    logic [7:0] reps_left;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_active;
    int m_k, m_h, m_l, m_r, m_p, m_idx, m_per;
    bit cur_start, cur_stop;
    logic [12:0] exp_v;
    logic [12:0] obs_v;

    always #5 clk = ~clk;

    pwm_burst_sequencer #(.W(8), .R(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_ready (start_ready),
        .stop        (stop),
        .high_len    (high_len),
        .low_len     (low_len),
        .reps        (reps),
        .busy        (busy),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .burst_done  (burst_done),
        .reps_left   (reps_left)
    );

    // Drive inputs for this cycle, wait for a quiet point, and compute the
    // expected output vector {busy,pwm,tick,done,ready,reps_left}.
    task automatic eval(input bit s, input bit sp);
        bit e_pwm, e_tick, e_bd;
        logic [7:0] e_rl;
        start     = s;
        stop      = sp;
        cur_start = s;
        cur_stop  = sp;
        @(negedge clk);
        obs_v = {busy, pwm_out, period_tick, burst_done, start_ready, reps_left};
        if (!m_active) begin
            exp_v = {5'b00001, 8'd0};
        end else begin
            m_per  = m_h + m_l + 2;
            m_idx  = (m_k - 1) / m_per;
            m_p    = (m_k - 1) % m_per;
            e_pwm  = (m_p <= m_h);
            e_tick = (m_p == m_per - 1) && !sp;
            e_bd   = e_tick && (m_r != 0) && (m_idx == m_r - 1);
            e_rl   = (m_r == 0) ? 8'd0 : 8'(m_r - m_idx);
            exp_v  = {1'b1, e_pwm, e_tick, e_bd, 1'b0, e_rl};
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (cur_stop) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (m_r != 0 && m_p == m_per - 1 && m_idx == m_r - 1) m_active = 1'b0;
            else m_k++;
        end else if (cur_start) begin
            m_active = 1'b1;
            m_k = 1;
            m_h = int'(high_len);
            m_l = int'(low_len);
            m_r = int'(reps);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        high_len = '0; low_len = '0; reps = '0;
        m_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, pwm_out, period_tick, burst_done, start_ready, reps_left} !== {5'b00001, 8'd0}) begin
            errors++;
            $display("FAIL reset_state got %h want %h",
                     {busy, pwm_out, period_tick, burst_done, start_ready, reps_left}, {5'b00001, 8'd0});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [7:0] pw_tab, tk_tab;
        pw_tab = 8'b0000_1110;
        tk_tab = 8'b0010_0000;
        high_len = 8'd2; low_len = 8'd1; reps = 8'd1;
        for (int i = 0; i < 8; i++) begin
            eval(i == 0, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL single cyc%0d got %h want %h", i, obs_v, exp_v);
            end
            checks++;
            if ({pwm_out, period_tick, burst_done} !== {pw_tab[i], tk_tab[i], tk_tab[i]}) begin
                errors++;
                $display("FAIL single_table cyc%0d got %b want %b", i,
                         {pwm_out, period_tick, burst_done}, {pw_tab[i], tk_tab[i], tk_tab[i]});
            end
            advance();
        end
    endtask

    task automatic test_multirep();
        logic [7:0] pw_tab, tk_tab, bd_tab;
        pw_tab = 8'b0010_1010;
        tk_tab = 8'b0101_0100;
        bd_tab = 8'b0100_0000;
        high_len = 8'd0; low_len = 8'd0; reps = 8'd3;
        for (int i = 0; i < 8; i++) begin
            eval(i == 0, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL multirep cyc%0d got %h want %h", i, obs_v, exp_v);
            end
            checks++;
            if ({pwm_out, period_tick, burst_done} !== {pw_tab[i], tk_tab[i], bd_tab[i]}) begin
                errors++;
                $display("FAIL multirep_table cyc%0d got %b want %b", i,
                         {pwm_out, period_tick, burst_done}, {pw_tab[i], tk_tab[i], bd_tab[i]});
            end
            advance();
        end
    endtask

    task automatic test_infinite();
        int ticks;
        ticks = 0;
        high_len = 8'd3; low_len = 8'd3; reps = 8'd0;
        // cycle 42 is the second cycle of a HIGH phase
        for (int i = 0; i < 45; i++) begin
            eval(i == 0, i == 42);
            if (period_tick) ticks++;
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL infinite cyc%0d got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
        checks++;
        if (ticks != 5) begin
            errors++;
            $display("FAIL infinite_tick_count got %0d want 5", ticks);
        end
    endtask

    task automatic test_stop_at_period_end();
        high_len = 8'd1; low_len = 8'd1; reps = 8'd2;
        for (int i = 0; i < 7; i++) begin
            eval(i == 0, i == 4);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL stop_period_end cyc%0d got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_config_isolation();
        int hcnt;
        high_len = 8'd2; low_len = 8'd2; reps = 8'd2;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) high_len = 8'd7;
            eval(i == 0 || i == 3 || i == 5, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL cfg_isolation cyc%0d got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
        hcnt = 0;
        reps = 8'd1;
        for (int i = 0; i < 14; i++) begin
            eval(i == 0, 1'b0);
            if (pwm_out) hcnt++;
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL cfg_restart cyc%0d got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
        checks++;
        if (hcnt != 8) begin
            errors++;
            $display("FAIL cfg_restart_high_len got %0d want 8", hcnt);
        end
    endtask

    task automatic test_async_reset();
        high_len = 8'd2; low_len = 8'd3; reps = 8'd3;
        for (int i = 0; i < 5; i++) begin
            eval(i == 0, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL pre_reset cyc%0d got %h want %h", i, obs_v, exp_v);
            end
            if (i < 4) advance();
        end
        // now mid-LOW, between clock edges
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, pwm_out, period_tick, burst_done, start_ready, reps_left} !== {5'b00001, 8'd0}) begin
            errors++;
            $display("FAIL async_reset got %h want %h",
                     {busy, pwm_out, period_tick, burst_done, start_ready, reps_left}, {5'b00001, 8'd0});
        end
        m_active = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        reps = 8'd1;
        for (int i = 0; i < 9; i++) begin
            eval(i == 0, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL post_reset cyc%0d got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        high_len = 8'd0; low_len = 8'd0; reps = 8'd1;
        // start & stop together in idle first, then start held high
        for (int i = 0; i < 8; i++) begin
            eval(1'b1, i == 0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
        eval(1'b0, 1'b0);
        advance();
        eval(1'b0, 1'b0);
        advance();
    endtask

    task automatic test_max_phase();
        high_len = 8'd255; low_len = 8'd0; reps = 8'd1;
        for (int i = 0; i < 260; i++) begin
            eval(i == 0, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL max_phase cyc%0d got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_random();
        int stop_at, cyc;
        for (int b = 0; b < 20; b++) begin
            high_len = 8'($urandom_range(0, 5));
            low_len  = 8'($urandom_range(0, 5));
            reps     = 8'($urandom_range(0, 4));
            if (reps == 0)                   stop_at = $urandom_range(3, 30);
            else if ($urandom_range(0, 3) == 0) stop_at = $urandom_range(1, 20);
            else                             stop_at = 1000;
            cyc = 0;
            while (cyc == 0 || m_active) begin
                if (cyc > 0 && $urandom_range(0, 3) == 0) begin
                    high_len = 8'($urandom_range(0, 255));
                    reps     = 8'($urandom_range(0, 255));
                end
                eval(cyc == 0 || $urandom_range(0, 4) == 0, cyc == stop_at);
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL random b%0d cyc%0d got %h want %h", b, cyc, obs_v, exp_v);
                end
                advance();
                cyc++;
                if (cyc > 200) begin
                    errors++;
                    $display("FAIL random_timeout b%0d got busy after %0d cycles want idle", b, cyc);
                    break;
                end
            end
            start = 1'b0; stop = 1'b1;
            @(posedge clk); #1;
            m_active = 1'b0;
            stop = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multirep();
        test_infinite();
        test_stop_at_period_end();
        test_config_isolation();
        test_async_reset();
        test_back_to_back();
        test_max_phase();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
